// File: rtl/timer_set_controller.sv
// rtl/timer_set_controller.sv - button-driven set/run/pause/alarm controller for a countdown timer
module timer_set_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALARM_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_inc,
  input  logic       zero,
  output logic [5:0] set,
  output logic       stop_start,
  output logic [2:0] digit_sel,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  localparam int AL_W = ($clog2(ALARM_CYCLES + 1) > 13) ? $clog2(ALARM_CYCLES + 1) : 13;
  localparam logic [AL_W-1:0] AL_LOAD = AL_W'(ALARM_CYCLES);
  localparam logic [AL_W-1:0] AL_ONE  = AL_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // bit 0 mode, bit 1 start, bit 2 inc
  logic [2:0]      btn_raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      lvl;
  logic [2:0]      lvl_q;
  logic [DB_W-1:0] db_cnt [3];

  logic mode_p;
  logic start_p;
  logic inc_lvl;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      digit_q;
  logic [2:0]      digit_d;
  logic [AL_W-1:0] acnt_q;
  logic [AL_W-1:0] acnt_d;

  assign btn_raw = {btn_inc, btn_start, btn_mode};

  // A level flips only after DEBOUNCE_CYCLES back-to-back samples that disagree with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          lvl[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  assign mode_p  = lvl[0] & ~lvl_q[0];
  assign start_p = lvl[1] & ~lvl_q[1];
  assign inc_lvl = lvl[2];

  // start_p is tested before mode_p everywhere, so a simultaneous mode_p is dropped
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    acnt_d  = acnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          if (!zero) state_d = ST_RUN;
        end else if (mode_p) begin
          state_d = ST_SET;
          digit_d = 3'd0;
        end
      end
      ST_SET: begin
        if (start_p) begin
          state_d = zero ? ST_IDLE : ST_RUN;
        end else if (mode_p) begin
          if (digit_q == 3'd5) begin
            state_d = ST_IDLE;
            digit_d = 3'd0;
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end
      end
      ST_RUN: begin
        if (zero) begin
          state_d = ST_DONE;
          acnt_d  = AL_LOAD;
        end else if (start_p) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_p) begin
          state_d = zero ? ST_IDLE : ST_RUN;
        end else if (mode_p) begin
          state_d = ST_SET;
          digit_d = 3'd0;
        end
      end
      ST_DONE: begin
        if (start_p || mode_p || acnt_q <= AL_ONE) begin
          state_d = ST_IDLE;
        end else begin
          acnt_d = acnt_q - AL_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      digit_q    <= 3'd0;
      acnt_q     <= '0;
      set        <= 6'd0;
      stop_start <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      acnt_q     <= acnt_d;
      set        <= (state_d == ST_SET && inc_lvl) ? (6'd1 << digit_d) : 6'd0;
      stop_start <= (state_d == ST_RUN);
      alarm      <= (state_d == ST_DONE);
    end
  end

  assign state     = state_q;
  assign digit_sel = digit_q;

endmodule

// File: tb/tb_timer_set_controller.sv
// tb/tb_timer_set_controller.sv - checks timer_set_controller against a window-based behavioural model
module tb_timer_set_controller;

  localparam int DB = 4;
  localparam int AL = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_inc = 1'b0;
  logic       zero = 1'b0;
  logic [5:0] set;
  logic       stop_start;
  logic [2:0] digit_sel;
  logic       alarm;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  bit done = 0;

  timer_set_controller #(.DEBOUNCE_CYCLES(DB), .ALARM_CYCLES(AL)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_start(btn_start),
    .btn_inc(btn_inc), .zero(zero), .set(set), .stop_start(stop_start),
    .digit_sel(digit_sel), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw history per button; a level flips when the D samples seen
  // two edges late all disagree with it. FSM follows the state table directly.
  int       m_state, m_digit, m_dc;
  bit       m_lvl[3];
  bit       m_prev[3];
  bit       m_hist[3][$];
  bit [5:0] m_set;
  bit       m_ss, m_alarm;

  task model_clear();
    m_state = 0; m_digit = 0; m_dc = 0;
    m_set = 0; m_ss = 0; m_alarm = 0;
    for (int b = 0; b < 3; b++) begin
      m_lvl[b] = 0;
      m_prev[b] = 0;
      m_hist[b].delete();
      for (int j = 0; j < DB + 2; j++) m_hist[b].push_back(1'b0);
    end
  endtask

  task model_step();
    bit raw[3];
    bit nl[3];
    bit mp, sp, inc, all;
    int ns, nd;
    raw = '{btn_mode, btn_start, btn_inc};
    mp  = m_lvl[0] && !m_prev[0];
    sp  = m_lvl[1] && !m_prev[1];
    inc = m_lvl[2];
    for (int b = 0; b < 3; b++) begin
      m_hist[b].push_back(raw[b]);
      void'(m_hist[b].pop_front());
      all = 1;
      for (int j = 0; j < DB; j++) if (m_hist[b][j] == m_lvl[b]) all = 0;
      nl[b] = all ? !m_lvl[b] : m_lvl[b];
    end
    ns = m_state;
    nd = m_digit;
    if (m_state == 0) begin
      if (sp) ns = zero ? 0 : 2;
      else if (mp) begin ns = 1; nd = 0; end
    end else if (m_state == 1) begin
      if (sp) ns = zero ? 0 : 2;
      else if (mp) begin
        if (m_digit == 5) begin ns = 0; nd = 0; end
        else nd = m_digit + 1;
      end
    end else if (m_state == 2) begin
      if (zero) ns = 4;
      else if (sp) ns = 3;
    end else if (m_state == 3) begin
      if (sp) ns = zero ? 0 : 2;
      else if (mp) begin ns = 1; nd = 0; end
    end else if (m_state == 4) begin
      m_dc++;
      if (sp || mp || m_dc >= AL) ns = 0;
    end
    if (ns == 4 && m_state != 4) m_dc = 0;
    m_set   = (ns == 1 && inc) ? 6'(1 << nd) : 6'd0;
    m_ss    = (ns == 2);
    m_alarm = (ns == 4);
    m_state = ns;
    m_digit = nd;
    for (int b = 0; b < 3; b++) begin
      m_prev[b] = m_lvl[b];
      m_lvl[b]  = nl[b];
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("m_state", state, m_state);
        chk("m_digit", digit_sel, m_digit);
        chk("m_set", set, m_set);
        chk("m_stop_start", stop_start, m_ss);
        chk("m_alarm", alarm, m_alarm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic drive(input int b, input bit v);
    case (b)
      0: btn_mode = v;
      1: btn_start = v;
      default: btn_inc = v;
    endcase
  endtask

  task automatic press(input int b, input int hold, input int gap);
    @(negedge clk);
    drive(b, 1'b1);
    repeat (hold) @(negedge clk);
    drive(b, 1'b0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_digit", digit_sel, 0);
    chk("rst_set", set, 0);
    chk("rst_ss", stop_start, 0);
    chk("rst_alarm", alarm, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // glitch shorter than the debounce window
    press(1, 3, 10);
    chk("glitch_state", state, 0);

    // digit walk with increment held at digit 2
    for (int i = 0; i < 7; i++) begin
      press(0, 8, 8);
      if (i < 6) begin
        chk("walk_state", state, 1);
        chk("walk_digit", digit_sel, i);
      end else begin
        chk("walk_end_state", state, 0);
        chk("walk_end_digit", digit_sel, 0);
      end
      if (i == 2) begin
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (8) @(negedge clk);
        chk("inc_set", set, 6'b000100);
        btn_inc = 1'b0;
        repeat (8) @(negedge clk);
        chk("inc_release", set, 0);
      end
    end

    // run / pause / stop with zero
    zero = 1'b0;
    press(1, 8, 8);
    chk("run_state", state, 2);
    chk("run_ss", stop_start, 1);
    press(1, 8, 8);
    chk("pause_state", state, 3);
    chk("pause_ss", stop_start, 0);
    zero = 1'b1;
    press(1, 8, 8);
    chk("pause_zero_state", state, 0);
    zero = 1'b0;

    // expiry with zero arriving in the same cycle as start_p
    press(1, 8, 8);
    chk("exp_run", state, 2);
    @(negedge clk);
    btn_start = 1'b1;
    repeat (6) @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    chk("exp_state", state, 4);
    chk("exp_alarm", alarm, 1);
    chk("exp_ss", stop_start, 0);
    n = 0;
    while (state == 3'd4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("alarm_len", n, AL);
    chk("exp_idle", state, 0);
    btn_start = 1'b0;
    zero = 1'b0;
    repeat (10) @(negedge clk);

    // park digit 3 in IDLE, then simultaneous mode+start
    for (int i = 0; i < 4; i++) press(0, 8, 8);
    chk("park_digit", digit_sel, 3);
    zero = 1'b1;
    press(1, 8, 8);
    chk("park_idle", state, 0);
    chk("park_hold", digit_sel, 3);
    press(1, 8, 8);
    chk("idle_zero_start", state, 0);
    zero = 1'b0;
    @(negedge clk);
    btn_mode = 1'b1;
    btn_start = 1'b1;
    repeat (8) @(negedge clk);
    btn_mode = 1'b0;
    btn_start = 1'b0;
    repeat (8) @(negedge clk);
    chk("simul_state", state, 2);
    chk("simul_digit", digit_sel, 3);

    // asynchronous reset while in DONE
    zero = 1'b1;
    @(negedge clk);
    chk("pre_rst_done", state, 4);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_alarm", alarm, 0);
    chk("arst_state", state, 0);
    chk("arst_digit", digit_sel, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    zero = 1'b0;
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    chk("db_early", state, 0);
    @(negedge clk);
    chk("db_full", state, 1);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);

    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
